jk_sync_counter: RTL and testbench
==================================

Name: jk_sync_counter

Overview:
- Synchronous modulo-MOD up/down counter. Every state bit is an explicit clocked JK flip-flop cell whose J/K excitation is generated per bit from count direction, load and enable.
- Clocked successor stage to the level-sensitive JK latch. Consumes the same j/k/enable semantics and exposes q/q_bar per bit.
- Feeds downstream display/decoder tasks with a count value, a terminal-count flag and a wrap pulse.

Parameters:
- WIDTH, 4, number of JK cells (count bits). Legal range 1..16.
- MOD, 10, count modulus. Legal range 2..2**WIDTH; counts 0..MOD-1.

Ports:
- clk  input  1  rising-edge clock for all JK cells.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count (JK cell outputs).
- q_bar  output  WIDTH  bitwise complement of q, always.
- tc  output  1  terminal count (combinational).
- wrap  output  1  one-cycle registered pulse on a wrap event.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a clk edge with rst=1, q=0, q_bar=all ones, wrap=0. rst overrides load and en. Asserting rst mid-count aborts the count on that edge.
- Cell model: each bit i updates on the clk rising edge as q_next = (J & ~q) | (~K & q). JK pairs behave as follows:
  - J=K=0: hold.
  - J=1, K=0: set.
  - J=0, K=1: clear.
  - J=K=1: toggle.
- All state changes go through J/K. No direct register assignment except reset.
- Priority per edge: rst > load > en > hold.
- Load (load=1, rst=0): J[i]=d[i], K[i]=~d[i]. Load takes effect regardless of en or up.
  - If d >= MOD, the value loaded is MOD-1 (clamp).
  - A load never produces a wrap pulse.
- Count (en=1, load=0, rst=0):
  - up=1, q<MOD-1: q becomes q+1. Cell i toggles (J=K=1) iff all lower bits are 1; otherwise J=K=0.
  - up=0, q>0: q becomes q-1. Cell i toggles iff all lower bits are 0.
  - up=1, q=MOD-1: q becomes 0. Excitation per bit: J=0, K=1 where q[i]=1; J=K=0 elsewhere.
  - up=0, q=0: q becomes MOD-1. Per bit: J=1, K=0 where (MOD-1)[i]=1; J=K=0 elsewhere.
- Out-of-range state (q>=MOD, only reachable if MOD < 2**WIDTH through an illegal sequence): the next enabled count edge forces q=0 via J=0/K=1.
- Hold (en=0, no load): J=K=0 on all cells; q is unchanged.
- tc = en & ~load & ((up & q==MOD-1) | (~up & q==0)). Purely combinational, same cycle.
- wrap: registered. wrap=1 for exactly the one cycle following an edge on which a count wrapped (tc=1 at that edge, rst=0). Otherwise 0.
- Direction change mid-count takes effect on the same edge. There is no pipelining; latency from en to q is 1 cycle.
- WIDTH=1, MOD=2 degenerates to a single toggle flip-flop. tc and wrap follow the rules above.

Optional Feature:
- Macro: JK_CNT_SATURATE_EN.
- Defined: the counter saturates instead of wrapping.
  - up=1 at q=MOD-1 holds MOD-1 (J=K=0).
  - up=0 at q=0 holds 0.
  - tc still asserts at the boundary.
  - wrap is tied to 0.
- Undefined: wrap-around behaviour as specified above.
- Load clamping and reset are identical in both builds.

Test Plan (WIDTH=4, MOD=10):
- Reset and count up:
  - rst=1 for 2 edges, then en=1, up=1 for 12 edges.
  - Required: q sequence 0,1,…,9,0,1,2; q_bar=~q every cycle.
  - tc=1 only while q=9.
  - wrap=1 exactly in the cycle with q=0 after 9.
- Count down across the wrap:
  - load d=2, then en=1, up=0 for 4 edges.
  - Required: q=2,1,0,9,8; tc=1 while q=0; wrap=1 in the cycle showing q=9.
- Load priority and clamp:
  - With en=1 and q=5, assert load with d=13.
  - Required: q=9 on the next edge and wrap=0.
  - Then load d=3 with en=1: q=3, with no increment.
- Hold and mid-count reset:
  - en=0 for 5 edges at q=6: q stays 6 and tc=0.
  - Then en=1, up=1, and rst=1 for one edge at q=7: q=0 and wrap=0 on that edge.
- Direction flip:
  - From q=4, up=1 for 2 edges, then up=0 for 3 edges.
  - Required: q=5,6,5,4,3.
- Saturate build (JK_CNT_SATURATE_EN defined):
  - up=1 from q=8 for 3 edges: q=9,9,9 with tc=1 at q=9.
  - up=0 from q=1 for 3 edges: q=0,0,0.
  - wrap is never 1.

Source files
------------

// File: rtl/jk_sync_counter.sv
// Modulo-MOD synchronous up/down counter built from explicit JK flip-flop cells.
// Define JK_CNT_SATURATE_EN to saturate at the count limits instead of wrapping.

module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  logic q_q;
  logic q_d;

  assign q_d = (j & ~q_q) | (~k & q_q);

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

module jk_sync_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_V = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] load_v;
  logic [WIDTH-1:0] inc_t;
  logic [WIDTH-1:0] dec_t;
  logic             at_max;
  logic             at_zero;
  logic             in_range;

  assign at_max   = (q_q == MAX_V);
  assign at_zero  = (q_q == '0);
  assign in_range = ({1'b0, q_q} < MOD_V);
  assign load_v   = ({1'b0, d} >= MOD_V) ? MAX_V : d;

  // A bit toggles on increment when all lower bits are 1, on decrement when all are 0.
  always_comb begin
    logic lower_ones;
    logic lower_zeros;
    inc_t       = '0;
    dec_t       = '0;
    lower_ones  = 1'b1;
    lower_zeros = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_t[i]    = lower_ones;
      dec_t[i]    = lower_zeros;
      lower_ones  = lower_ones & q_q[i];
      lower_zeros = lower_zeros & ~q_q[i];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (load) begin
      j = load_v;
      k = ~load_v;
    end else if (en) begin
      if (!in_range) begin
        k = '1;
      end else if (up) begin
        if (at_max) begin
`ifdef JK_CNT_SATURATE_EN
          j = '0;
          k = '0;
`else
          k = q_q;
`endif
        end else begin
          j = inc_t;
          k = inc_t;
        end
      end else begin
        if (at_zero) begin
`ifdef JK_CNT_SATURATE_EN
          j = '0;
          k = '0;
`else
          j = MAX_V;
`endif
        end else begin
          j = dec_t;
          k = dec_t;
        end
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[gi]),
      .k   (k[gi]),
      .q   (q_q[gi])
    );
  end

  assign q     = q_q;
  assign q_bar = ~q_q;
  assign tc    = en & ~load & ((up & at_max) | (~up & at_zero));

`ifdef JK_CNT_SATURATE_EN
  assign wrap = 1'b0;
`else
  logic wrap_q;
  logic wrap_d;

  // tc with no load means this edge rolls the count over the boundary.
  assign wrap_d = tc;

  always_ff @(posedge clk) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;
`endif
endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed bench for jk_sync_counter (WIDTH=4, MOD=10); expected values are hand-derived
// and checked by a negedge monitor draining a scoreboard queue.

module tb_jk_sync_counter;
  localparam int W = 4;
  localparam int EW = 2 * W + 2;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         tc;
  logic         wrap;

  logic [EW-1:0] exp_q[$];
  int            vectors;
  int            miscompares;

  jk_sync_counter #(.WIDTH(W), .MOD(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .up    (up),
    .load  (load),
    .d     (d),
    .q     (q),
    .q_bar (q_bar),
    .tc    (tc),
    .wrap  (wrap)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: applies inputs just after an edge and queues the outputs expected
  // during the cycle that follows (state from the previous edge, tc under new inputs).
  task automatic apply(input logic r, input logic e, input logic u, input logic l,
                       input logic [W-1:0] dv, input logic [W-1:0] eq,
                       input logic etc, input logic ew);
    logic [W-1:0] eqb;
    rst  = r;
    en   = e;
    up   = u;
    load = l;
    d    = dv;
    eqb  = ~eq;
    exp_q.push_back({eq, eqb, etc, ew});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {q, q_bar, tc, wrap};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL vec%0d: got q=%0d q_bar=%h tc=%b wrap=%b, expected q=%0d q_bar=%h tc=%b wrap=%b",
                 vectors, q, q_bar, tc, wrap,
                 exp_v[EW-1 -: W], exp_v[W+1 -: W], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    en   = 1'b0;
    up   = 1'b0;
    load = 1'b0;
    d    = '0;
    @(posedge clk);
    #1;

    // Reset held for two more edges
    apply(1, 0, 0, 0, 0, 4'd0, 0, 0);
    apply(1, 0, 0, 0, 0, 4'd0, 0, 0);

`ifdef JK_CNT_SATURATE_EN
    // Saturate at the top
    apply(0, 0, 1, 1, 8, 4'd0, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd8, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd9, 1, 0);
    apply(0, 1, 1, 0, 0, 4'd9, 1, 0);
    // Saturate at the bottom
    apply(0, 0, 0, 1, 1, 4'd9, 0, 0);
    apply(0, 1, 0, 0, 0, 4'd1, 0, 0);
    apply(0, 1, 0, 0, 0, 4'd0, 1, 0);
    apply(0, 1, 0, 0, 0, 4'd0, 1, 0);
    apply(0, 0, 0, 1, 8, 4'd0, 0, 0);
`else
    // Count up through the wrap: 0..9,0,1
    apply(0, 1, 1, 0, 0, 4'd0, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd1, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd2, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd3, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd4, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd5, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd6, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd7, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd8, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd9, 1, 0);
    apply(0, 1, 1, 0, 0, 4'd0, 0, 1);
    apply(0, 1, 1, 0, 0, 4'd1, 0, 0);
    // Load 2 and count down across the wrap
    apply(0, 0, 0, 1, 2, 4'd2, 0, 0);
    apply(0, 1, 0, 0, 0, 4'd2, 0, 0);
    apply(0, 1, 0, 0, 0, 4'd1, 0, 0);
    apply(0, 1, 0, 0, 0, 4'd0, 1, 0);
    apply(0, 1, 0, 0, 0, 4'd9, 0, 1);
`endif

    // Load priority over count, and clamp of out-of-range load data
    apply(0, 1, 0, 1, 5, 4'd8, 0, 0);
    apply(0, 1, 1, 1, 13, 4'd5, 0, 0);
    apply(0, 1, 1, 1, 3, 4'd9, 0, 0);
    apply(0, 0, 1, 1, 6, 4'd3, 0, 0);

    // Hold for five edges at 6
    apply(0, 0, 1, 0, 0, 4'd6, 0, 0);
    apply(0, 0, 1, 0, 0, 4'd6, 0, 0);
    apply(0, 0, 1, 0, 0, 4'd6, 0, 0);
    apply(0, 0, 1, 0, 0, 4'd6, 0, 0);
    apply(0, 0, 1, 0, 0, 4'd6, 0, 0);

    // Mid-count reset at 7
    apply(0, 1, 1, 0, 0, 4'd6, 0, 0);
    apply(1, 1, 1, 0, 0, 4'd7, 0, 0);
    apply(0, 0, 1, 0, 0, 4'd0, 0, 0);

    // Reset on an edge where tc is high must not produce a wrap pulse
    apply(0, 0, 1, 1, 9, 4'd0, 0, 0);
    apply(1, 1, 1, 0, 0, 4'd9, 1, 0);
    apply(0, 0, 1, 0, 0, 4'd0, 0, 0);

    // Direction flip: 4 -> 5,6 -> 5,4,3
    apply(0, 0, 1, 1, 4, 4'd0, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd4, 0, 0);
    apply(0, 1, 1, 0, 0, 4'd5, 0, 0);
    apply(0, 1, 0, 0, 0, 4'd6, 0, 0);
    apply(0, 1, 0, 0, 0, 4'd5, 0, 0);
    apply(0, 1, 0, 0, 0, 4'd4, 0, 0);
    apply(0, 0, 0, 0, 0, 4'd3, 0, 0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
